// File: rtl/matmul_stream.sv
// matmul_stream: streaming matrix multiplier C = A x B.
// A (ROWS_A x COLS_A) then B (COLS_A x COLS_B) arrive row-major on `in`;
// C is produced row-major on `out`, one element per output handshake,
// with one MAC per cycle while computing.
// Optional build macro: MATMUL_SAT_EN -- when defined, narrowing of the
// accumulator to OUT_WIDTH saturates; when undefined it wraps.
module matmul_stream #(
    parameter int ROWS_A     = 2,
    parameter int COLS_A     = 2,
    parameter int COLS_B     = 2,
    parameter int DATA_WIDTH = 16,
    // Derived accumulator width; not meant to be overridden.
    parameter int ACC_W      = 2 * DATA_WIDTH + $clog2(COLS_A) + 1,
    parameter int OUT_WIDTH  = ACC_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_mode,
    input  logic [DATA_WIDTH-1:0] in,
    input  logic                  valid_in,
    output logic                  ready_in,
    output logic [OUT_WIDTH-1:0]  out,
    output logic                  valid_out,
    input  logic                  ready_out,
    output logic                  last
);

    localparam int NA  = ROWS_A * COLS_A;
    localparam int NB  = COLS_A * COLS_B;
    localparam int AAW = (NA > 1) ? $clog2(NA) : 1;
    localparam int BAW = (NB > 1) ? $clog2(NB) : 1;
    localparam int LW  = (AAW > BAW) ? AAW : BAW;
    localparam int IW  = (ROWS_A > 1) ? $clog2(ROWS_A) : 1;
    localparam int JW  = (COLS_B > 1) ? $clog2(COLS_B) : 1;
    localparam int KW  = (COLS_A > 1) ? $clog2(COLS_A) : 1;

    localparam logic [LW-1:0] NA_LAST = LW'(NA - 1);
    localparam logic [LW-1:0] NB_LAST = LW'(NB - 1);
    localparam logic [IW-1:0] I_LAST  = IW'(ROWS_A - 1);
    localparam logic [JW-1:0] J_LAST  = JW'(COLS_B - 1);
    localparam logic [KW-1:0] K_LAST  = KW'(COLS_A - 1);

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        COMPUTE = 2'd2,
        OUTPUT  = 2'd3
    } state_t;

    // Extend one operand to the accumulator width, sign or zero per mode.
    function automatic logic signed [ACC_W-1:0] ext(input logic [DATA_WIDTH-1:0] v,
                                                    input logic sgn);
        ext = {{(ACC_W-DATA_WIDTH){sgn & v[DATA_WIDTH-1]}}, v};
    endfunction

`ifdef MATMUL_SAT_EN
    // Clamp the accumulator into the OUT_WIDTH range of the active mode.
    function automatic logic [OUT_WIDTH-1:0] narrow(input logic signed [ACC_W-1:0] v,
                                                    input logic sgn);
        logic signed [ACC_W-1:0] hi;
        if (sgn) begin
            hi = v >>> (OUT_WIDTH - 1);
            if (hi == '0 || hi == '1) begin
                narrow = v[OUT_WIDTH-1:0];
            end else if (v[ACC_W-1]) begin
                narrow = {1'b1, {(OUT_WIDTH-1){1'b0}}};
            end else begin
                narrow = {1'b0, {(OUT_WIDTH-1){1'b1}}};
            end
        end else begin
            // Unsigned sums are never negative, so only the top needs a clamp.
            hi = v >>> OUT_WIDTH;
            if (hi == '0) begin
                narrow = v[OUT_WIDTH-1:0];
            end else begin
                narrow = {OUT_WIDTH{1'b1}};
            end
        end
    endfunction
`endif

    state_t                  st_q, st_d;
    logic [LW-1:0]           ld_q, ld_d;
    logic [IW-1:0]           i_q, i_d;
    logic [JW-1:0]           j_q, j_d;
    logic [KW-1:0]           k_q, k_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [OUT_WIDTH-1:0]    out_q, out_d;
    logic                    vo_q, vo_d;
    logic                    last_q, last_d;
    logic                    mode_q, mode_d;
    logic                    rdy_q, rdy_d;

    logic [DATA_WIDTH-1:0]   a_mem [0:(1<<AAW)-1];
    logic [DATA_WIDTH-1:0]   b_mem [0:(1<<BAW)-1];

    logic                    hs_in_s;
    logic [AAW-1:0]          a_idx_s;
    logic [BAW-1:0]          b_idx_s;
    logic signed [ACC_W-1:0] prod_s;
    logic signed [ACC_W-1:0] sum_s;
    logic [OUT_WIDTH-1:0]    nar_s;

    assign hs_in_s = valid_in & rdy_q;
    assign a_idx_s = AAW'(int'(i_q) * COLS_A + int'(k_q));
    assign b_idx_s = BAW'(int'(k_q) * COLS_B + int'(j_q));
    // Exact: the true product always fits in ACC_W signed bits.
    assign prod_s  = ext(a_mem[a_idx_s], mode_q) * ext(b_mem[b_idx_s], mode_q);
    assign sum_s   = ((k_q == '0) ? {ACC_W{1'b0}} : acc_q) + prod_s;

`ifdef MATMUL_SAT_EN
    assign nar_s = narrow(sum_s, mode_q);
`else
    assign nar_s = sum_s[OUT_WIDTH-1:0];
`endif

    assign ready_in  = rdy_q;
    assign out       = out_q;
    assign valid_out = vo_q;
    assign last      = last_q;

    // Operand storage written in arrival order; contents survive reset.
    always_ff @(posedge clk) begin
        if (hs_in_s && st_q == LOAD_A) a_mem[AAW'(ld_q)] <= in;
        if (hs_in_s && st_q == LOAD_B) b_mem[BAW'(ld_q)] <= in;
    end

    // Next-state logic: load sequencing, MAC stepping and output hand-off.
    always_comb begin
        st_d   = st_q;
        ld_d   = ld_q;
        i_d    = i_q;
        j_d    = j_q;
        k_d    = k_q;
        acc_d  = acc_q;
        out_d  = out_q;
        vo_d   = vo_q;
        last_d = last_q;
        mode_d = mode_q;
        case (st_q)
            LOAD_A: begin
                if (hs_in_s) begin
                    if (ld_q == '0) mode_d = signed_mode;
                    else            mode_d = mode_q;
                    if (ld_q == NA_LAST) begin
                        ld_d = '0;
                        st_d = LOAD_B;
                    end else begin
                        ld_d = ld_q + LW'(1);
                    end
                end else begin
                    ld_d = ld_q;
                end
            end
            LOAD_B: begin
                if (hs_in_s) begin
                    if (ld_q == NB_LAST) begin
                        ld_d = '0;
                        st_d = COMPUTE;
                    end else begin
                        ld_d = ld_q + LW'(1);
                    end
                end else begin
                    ld_d = ld_q;
                end
            end
            COMPUTE: begin
                acc_d = sum_s;
                if (k_q == K_LAST) begin
                    k_d    = '0;
                    out_d  = nar_s;
                    vo_d   = 1'b1;
                    last_d = (i_q == I_LAST) && (j_q == J_LAST);
                    st_d   = OUTPUT;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            OUTPUT: begin
                if (ready_out) begin
                    vo_d   = 1'b0;
                    last_d = 1'b0;
                    if (last_q) begin
                        i_d  = '0;
                        j_d  = '0;
                        st_d = LOAD_A;
                    end else if (j_q == J_LAST) begin
                        j_d  = '0;
                        i_d  = i_q + IW'(1);
                        st_d = COMPUTE;
                    end else begin
                        j_d  = j_q + JW'(1);
                        st_d = COMPUTE;
                    end
                end else begin
                    st_d = OUTPUT;
                end
            end
            default: begin
                st_d = LOAD_A;
            end
        endcase
        rdy_d = (st_d == LOAD_A) || (st_d == LOAD_B);
    end

    // State, counter and output registers; reset discards any partial matrix.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q   <= LOAD_A;
            ld_q   <= '0;
            i_q    <= '0;
            j_q    <= '0;
            k_q    <= '0;
            acc_q  <= '0;
            out_q  <= '0;
            vo_q   <= 1'b0;
            last_q <= 1'b0;
            mode_q <= 1'b0;
            rdy_q  <= 1'b0;
        end else begin
            st_q   <= st_d;
            ld_q   <= ld_d;
            i_q    <= i_d;
            j_q    <= j_d;
            k_q    <= k_d;
            acc_q  <= acc_d;
            out_q  <= out_d;
            vo_q   <= vo_d;
            last_q <= last_d;
            mode_q <= mode_d;
            rdy_q  <= rdy_d;
        end
    end

endmodule

// File: tb/tb_matmul_stream.sv
// Bench for matmul_stream: three instances (2x2x2 full width, 2x2x2 with
// 8-bit output, 2x3x1 full width) against a plain-arithmetic matrix model.
module tb_matmul_stream;

    localparam int DW  = 16;
    localparam int AW0 = 2 * DW + 1 + 1;   // 2x2x2 accumulator width
    localparam int AW1 = 2 * DW + 2 + 1;   // 2x3x1 accumulator width

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int grp    = 0;

    logic [DW-1:0] in_v;
    logic          valid_v, ready_out_v, mode_v;

    logic           ready_in0, valid_out0, last0;
    logic [AW0-1:0] out0;
    logic           ready_in8, valid_out8, last8;
    logic [7:0]     out8;
    logic           ready_in1, valid_out1, last1;
    logic [AW1-1:0] out1;

    logic        valid_in0, valid_in1, ready_out0, ready_out1;
    logic        cur_ready_in, cur_valid_out, cur_last;
    logic [63:0] cur_out;

    assign valid_in0     = (grp == 0) && valid_v;
    assign valid_in1     = (grp == 1) && valid_v;
    assign ready_out0    = (grp == 0) && ready_out_v;
    assign ready_out1    = (grp == 1) && ready_out_v;
    assign cur_ready_in  = (grp == 1) ? ready_in1  : ready_in0;
    assign cur_valid_out = (grp == 1) ? valid_out1 : valid_out0;
    assign cur_last      = (grp == 1) ? last1      : last0;
    assign cur_out       = (grp == 1) ? 64'(out1)  : 64'(out0);

    matmul_stream #(.ROWS_A(2), .COLS_A(2), .COLS_B(2), .DATA_WIDTH(DW)) dut0 (
        .clk(clk), .rst(rst), .signed_mode(mode_v), .in(in_v), .valid_in(valid_in0),
        .ready_in(ready_in0), .out(out0), .valid_out(valid_out0), .ready_out(ready_out0),
        .last(last0));

    matmul_stream #(.ROWS_A(2), .COLS_A(2), .COLS_B(2), .DATA_WIDTH(DW), .OUT_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .signed_mode(mode_v), .in(in_v), .valid_in(valid_in0),
        .ready_in(ready_in8), .out(out8), .valid_out(valid_out8), .ready_out(ready_out0),
        .last(last8));

    matmul_stream #(.ROWS_A(2), .COLS_A(3), .COLS_B(1), .DATA_WIDTH(DW)) dut1 (
        .clk(clk), .rst(rst), .signed_mode(mode_v), .in(in_v), .valid_in(valid_in1),
        .ready_in(ready_in1), .out(out1), .valid_out(valid_out1), .ready_out(ready_out1),
        .last(last1));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint elem(input logic [DW-1:0] v, input bit m);
        if (m) return longint'($signed(v));
        else   return longint'({48'd0, v});
    endfunction

    function automatic logic [63:0] mask(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    // Reference narrowing to 8 bits for the OUT_WIDTH=8 instance.
    function automatic logic [63:0] narrow8(input longint c, input bit m);
        longint r;
        r = c;
`ifdef MATMUL_SAT_EN
        if (m) begin
            if (r > 127) r = 127;
            else if (r < -128) r = -128;
        end else if (r > 255) begin
            r = 255;
        end
`else
        if (m) r = c;
`endif
        return 64'(r) & 64'hFF;
    endfunction

    task automatic feed(input logic [DW-1:0] v, input bit gaps);
        int n;
        if (gaps) begin
            valid_v = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
        end
        in_v    = v;
        valid_v = 1'b1;
        n       = 0;
        while (!cur_ready_in && n < 40) begin
            tick();
            n++;
        end
        chk("ready_in_wait", 64'(n < 40), 64'd1);
        tick();
        valid_v = 1'b0;
    endtask

    // Load one matrix pair into group g and check every result element.
    task automatic run(input int g, input bit m, input logic [DW-1:0] a[$],
                       input logic [DW-1:0] b[$], input int smin, input int smax,
                       input bit gaps);
        int ra, ca, cb, aw, lat, st;
        longint c[$];
        longint s;
        logic [63:0] o, o8;
        logic l;
        grp = g;
        ra  = 2;
        ca  = (g == 1) ? 3 : 2;
        cb  = (g == 1) ? 1 : 2;
        aw  = (g == 1) ? AW1 : AW0;
        for (int i = 0; i < ra; i++)
            for (int j = 0; j < cb; j++) begin
                s = 0;
                for (int k = 0; k < ca; k++)
                    s += elem(a[i*ca+k], m) * elem(b[k*cb+j], m);
                c.push_back(s);
            end
        mode_v = m;
        for (int x = 0; x < a.size(); x++) begin
            feed(a[x], gaps);
            if (x == 0) mode_v = 1'($urandom_range(0, 1));
        end
        for (int x = 0; x < b.size(); x++) feed(b[x], gaps);
        for (int e = 0; e < c.size(); e++) begin
            lat = 0;
            while (!cur_valid_out && lat < 40) begin
                tick();
                lat++;
            end
            chk("latency", 64'(lat), 64'(ca));
            chk("out", cur_out, 64'(c[e]) & mask(aw));
            chk("last", 64'(cur_last), 64'(e == c.size() - 1));
            chk("ready_in_busy", 64'(cur_ready_in), 64'd0);
            if (g == 0) begin
                chk("out8", 64'(out8), narrow8(c[e], m));
                chk("valid8", 64'(valid_out8), 64'd1);
            end
            o  = cur_out;
            o8 = 64'(out8);
            l  = cur_last;
            st = $urandom_range(smin, smax);
            for (int t = 0; t < st; t++) begin
                ready_out_v = 1'b0;
                tick();
                chk("stall_out", cur_out, o);
                chk("stall_valid", 64'(cur_valid_out), 64'd1);
                chk("stall_last", 64'(cur_last), 64'(l));
                chk("stall_ready_in", 64'(cur_ready_in), 64'd0);
                if (g == 0) chk("stall_out8", 64'(out8), o8);
            end
            ready_out_v = 1'b1;
            tick();
            chk("valid_drop", 64'(cur_valid_out), 64'd0);
            if (e == c.size() - 1) chk("ready_after_last", 64'(cur_ready_in), 64'd1);
        end
    endtask

    logic [DW-1:0] qa[$];
    logic [DW-1:0] qb[$];
    logic [DW-1:0] a42[$];
    logic [DW-1:0] b42[$];

    initial begin
        rst         = 1'b0;
        in_v        = '0;
        valid_v     = 1'b0;
        ready_out_v = 1'b1;
        mode_v      = 1'b0;
        grp         = 0;
        a42         = '{16'd1, 16'd2, 16'd3, 16'd4};
        b42         = '{16'd100, 16'd101, 16'd102, 16'd103};

        #1;
        chk("rst_out", 64'(out0), 64'd0);
        chk("rst_valid", 64'(valid_out0), 64'd0);
        chk("rst_last", 64'(last0), 64'd0);
        chk("rst_ready", 64'(ready_in0), 64'd0);
        chk("rst_out8", 64'(out8), 64'd0);
        chk("rst_ready1", 64'(ready_in1), 64'd0);
        tick();
        tick();
        rst = 1'b1;
        chk("ready_before_edge", 64'(ready_in0), 64'd0);
        tick();
        chk("ready_after_release", 64'(ready_in0), 64'd1);

        // Unsigned reference case, then signed, then heavy back-pressure.
        run(0, 1'b0, a42, b42, 0, 0, 1'b0);
        qa = '{16'hFFFF, 16'd2, 16'hFFFD, 16'd4};
        run(0, 1'b1, qa, b42, 0, 0, 1'b0);
        run(0, 1'b0, a42, b42, 5, 5, 1'b0);

        // Reset in the middle of loading A discards the partial matrix.
        grp = 0;
        for (int x = 0; x < 3; x++) feed(a42[x], 1'b0);
        rst = 1'b0;
        #1;
        chk("midrst_valid", 64'(valid_out0), 64'd0);
        chk("midrst_ready", 64'(ready_in0), 64'd0);
        tick();
        chk("midrst_hold_valid", 64'(valid_out0), 64'd0);
        rst = 1'b1;
        tick();
        chk("midrst_recovered", 64'(ready_in0), 64'd1);
        chk("midrst_no_output", 64'(valid_out0), 64'd0);
        run(0, 1'b0, a42, b42, 0, 0, 1'b0);

        // 2x3x1 shape, two matrix pairs back to back.
        qa = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6};
        qb = '{16'd1, 16'd1, 16'd1};
        run(1, 1'b0, qa, qb, 0, 0, 1'b0);
        run(1, 1'b0, qa, qb, 0, 0, 1'b0);

        // Random data, modes, input gaps and output stalls.
        for (int r = 0; r < 8; r++) begin
            qa.delete();
            qb.delete();
            for (int x = 0; x < 4; x++) qa.push_back(16'($urandom_range(0, 65535)));
            for (int x = 0; x < 4; x++) qb.push_back(16'($urandom_range(0, 65535)));
            run(0, 1'($urandom_range(0, 1)), qa, qb, 0, 3, 1'b1);
        end
        for (int r = 0; r < 4; r++) begin
            qa.delete();
            qb.delete();
            for (int x = 0; x < 6; x++) qa.push_back(16'($urandom_range(0, 65535)));
            for (int x = 0; x < 3; x++) qb.push_back(16'($urandom_range(0, 65535)));
            run(1, 1'($urandom_range(0, 1)), qa, qb, 0, 2, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
